lsu_mem_stage: RTL and testbench
================================

// Module: lsu_mem_stage
// PURPOSE
//  MEM-stage load/store unit, directly upstream of the dcache.
//  - Accepts one memory op at a time from EX and drives dcache_if as master.
//  - Holds all request fields stable for the whole dcache transaction. The dcache samples
//    the live req_addr/size/sign/write_en in every state, not only on req_valid.
//  - Traps misaligned accesses without touching the dcache.
//  - Returns load data to WB and stalls EX while busy.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles waiting for dcache completion before a bus-error trap
//  TO_W            10    width of timeout counter, must satisfy 2**TO_W >= TIMEOUT_CYCLES
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  ex_valid       in   1   EX presents a memory op
//  ex_ready       out  1   LSU accepts op this cycle (ex_valid & ex_ready = accept)
//  ex_is_store    in   1   1=store, 0=load
//  ex_addr        in   32  effective byte address
//  ex_wdata       in   32  store data, LSB-aligned (rs2)
//  ex_size        in   2   MEM_SIZE_B/H/W encoding
//  ex_sign        in   1   load sign-extend
//  ex_rd          in   5   load destination register
//  flush          in   1   pipeline flush (branch/trap)
//  wb_valid       out  1   one-cycle pulse: load data ready
//  wb_rd          out  5   destination of returned load
//  wb_data        out  32  load data, already extended by the dcache
//  exc_valid      out  1   one-cycle pulse: trap; valid on the same cycle as exc_cause/exc_addr
//  exc_cause      out  2   0=load misalign, 1=store misalign, 2=bus timeout
//  exc_addr       out  32  faulting address
//  dcache_if      master   req_valid, write_en, req_addr, write_data, size, sign out;
//                          resp_data, resp_valid, resp_ready in
// BEHAVIOUR
//  Reset values
//  - All outputs 0 except ex_ready=1. State IDLE. Latched op cleared.
//  Accept and misalign check (IDLE)
//  - On accept, the op latches into op_q. dcache_if write_en/req_addr/write_data/size/sign
//    drive from op_q continuously, never combinationally from EX.
//  - Misaligned means: H with addr[0]=1, or W with addr[1:0]!=0.
//  - A misaligned op is detected at accept (combinational check on ex_addr/ex_size). Next
//    cycle: exc_valid=1 with exc_cause/exc_addr, no dcache request, state stays IDLE.
//  States
//  - IDLE: ex_ready=1. A legal accept goes to ISSUE.
//  - ISSUE: ex_ready=0. req_valid=1 only while resp_ready=1; req_valid stays 0 otherwise.
//    req_valid is asserted for exactly one cycle. Next state WAIT_BUSY.
//  - WAIT_BUSY: wait until resp_ready=0, meaning the dcache has left IDLE.
//    For a load, resp_valid=1 is also accepted here.
//  - WAIT_DONE:
//    - Load: on resp_valid, capture resp_data. Next cycle wb_valid=1, wb_rd=op_q.rd. Go IDLE.
//    - Store: on resp_ready rising back to 1, the store is complete. Go IDLE; no wb pulse.
//    - If resp_valid and the resp_ready rise arrive in the same cycle, resp_valid wins for
//      loads. Only one wb pulse per op.
//  Throughput and latency
//  - Back-to-back ops: a new op is accepted the cycle after returning to IDLE
//    (ex_ready=1 in IDLE only).
//  - Load hit latency: accept -> wb_valid = 4 cycles.
//  Timeout
//  - Counter clears on accept and increments in WAIT_BUSY/WAIT_DONE.
//  - At TIMEOUT_CYCLES-1: exc_valid with cause 2, go IDLE. Later dcache responses are
//    ignored until the next ISSUE.
//  Flush
//  - In ISSUE before req_valid is asserted: drop the op, go IDLE, no outputs.
//  - After issue: the dcache transaction is never aborted. The op completes; for a load,
//    wb_valid is suppressed and the data is discarded.
//  - flush and accept in the same cycle: the accept is ignored.
//  Reset mid-operation
//  - Returns to IDLE immediately. The dcache resets on the same rst_n.
// TESTING
//  1. LW 0x100, dcache hit returns 0xDEADBEEF -> req_valid exactly 1 cycle; req_addr held at
//     0x100 until wb_valid; wb_data=0xDEADBEEF, wb_rd=ex_rd.
//  2. SW 0x204, data 0x12345678, dcache miss with refill -> write_en=1 and write_data stable
//     for the whole miss; ex_ready=1 only after resp_ready returns high; no wb_valid.
//  3. LH 0x101 -> exc_valid, cause 0, exc_addr 0x101. SW 0x202 -> cause 1.
//     No req_valid in either case.
//  4. LB 0x300, flush 3 cycles after issue during the refill -> AXI refill completes;
//     wb_valid never pulses; next op is accepted normally.
//  5. Load with resp_ready held 0 (TIMEOUT_CYCLES=16) -> exc_valid cause 2 at the 16th wait
//     cycle; a late resp_valid produces no wb_valid.
//  6. rst_n low in WAIT_DONE -> all outputs at reset values asynchronously; ex_ready=1.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: takes one op from EX, runs it on the dcache, returns
// load data to WB and raises misalign/timeout traps.
//
// state     | meaning
// IDLE      | ready for a new op from EX
// ISSUE     | op latched, waiting for dcache ready to pulse req_valid
// WAIT_BUSY | request sent, waiting for the dcache to drop resp_ready
// WAIT_DONE | dcache busy, waiting for resp_valid (load) or resp_ready (store)
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_store,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [1:0]  ex_size,
  input  logic        ex_sign,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr,
  output logic        dcache_req_valid,
  output logic        dcache_write_en,
  output logic [31:0] dcache_req_addr,
  output logic [31:0] dcache_write_data,
  output logic [1:0]  dcache_size,
  output logic        dcache_sign,
  input  logic [31:0] dcache_resp_data,
  input  logic        dcache_resp_valid,
  input  logic        dcache_resp_ready
);

  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  typedef struct packed {
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  rd;
  } op_t;

  state_t          state;
  op_t             op_q;
  logic [TO_W-1:0] to_cnt;
  logic            flushed_q;
  logic            accept;
  logic            misaligned;
  logic            to_done;
  logic            drop;
  logic            load_resp;
  logic            store_done;

  assign ex_ready   = (state == IDLE);
  assign accept     = ex_valid && ex_ready && !flush;
  assign misaligned = ((ex_size == MEM_SIZE_H) && ex_addr[0]) ||
                      ((ex_size == MEM_SIZE_W) && (ex_addr[1:0] != 2'b00));
  assign to_done    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign drop       = flushed_q || flush;
  assign load_resp  = !op_q.is_store && dcache_resp_valid;
  assign store_done = op_q.is_store && (state == WAIT_DONE) && dcache_resp_ready;

  // A flush in the same cycle as the handshake wins: the request is never sent.
  assign dcache_req_valid  = (state == ISSUE) && dcache_resp_ready && !flush;
  assign dcache_write_en   = op_q.is_store;
  assign dcache_req_addr   = op_q.addr;
  assign dcache_write_data = op_q.wdata;
  assign dcache_size       = op_q.size;
  assign dcache_sign       = op_q.sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      to_cnt    <= '0;
      flushed_q <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= '{ex_is_store, ex_addr, ex_wdata, ex_size, ex_sign, ex_rd};
            to_cnt    <= '0;
            flushed_q <= 1'b0;
            if (misaligned) begin
              exc_valid <= 1'b1;
              exc_cause <= ex_is_store ? 2'd1 : 2'd0;
              exc_addr  <= ex_addr;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush) state <= IDLE;
          else if (dcache_resp_ready) state <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          // The dcache transaction always runs to completion; a flush only mutes the result.
          if (flush) flushed_q <= 1'b1;
          if (load_resp) begin
            if (!drop) begin
              wb_valid <= 1'b1;
              wb_rd    <= op_q.rd;
              wb_data  <= dcache_resp_data;
            end
            state <= IDLE;
          end else if (store_done) begin
            state <= IDLE;
          end else if (to_done) begin
            if (!drop) begin
              exc_valid <= 1'b1;
              exc_cause <= 2'd2;
              exc_addr  <= op_q.addr;
            end
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if ((state == WAIT_BUSY) && !dcache_resp_ready) state <= WAIT_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a vector table of loads/stores/misaligned ops plus
// hand-written flush, timeout and reset sequences against a scripted dcache.
module tb_lsu_mem_stage;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready, ex_is_store = 1'b0, ex_sign = 1'b0, flush = 1'b0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [1:0]  ex_size = '0;
  logic [4:0]  ex_rd = '0;
  logic        wb_valid, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [1:0]  exc_cause;
  logic        req_valid, write_en, d_sign;
  logic [31:0] req_addr, write_data;
  logic [1:0]  d_size;
  logic [31:0] resp_data = '0;
  logic        resp_valid = 1'b0, resp_ready = 1'b1;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_size(ex_size), .ex_sign(ex_sign),
    .ex_rd(ex_rd), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .dcache_req_valid(req_valid), .dcache_write_en(write_en), .dcache_req_addr(req_addr),
    .dcache_write_data(write_data), .dcache_size(d_size), .dcache_sign(d_sign),
    .dcache_resp_data(resp_data), .dcache_resp_valid(resp_valid),
    .dcache_resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        is_store;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    logic        exp_exc;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic st, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [4:0] rd, input logic [31:0] wd);
    ex_valid = 1'b1; ex_is_store = st; ex_addr = a; ex_size = sz;
    ex_sign = sg; ex_rd = rd; ex_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    drive_op(v.is_store, v.addr, v.size, v.sign, v.rd, v.wdata);
    #1 chk("ex_ready_idle", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    #1;
    if (v.exp_exc) begin
      chk("mis_exc_valid", exc_valid, 1);
      chk("mis_exc_cause", exc_cause, v.exp_cause);
      chk("mis_exc_addr", exc_addr, v.addr);
      chk("mis_no_req", req_valid, 0);
      chk("mis_ex_ready", ex_ready, 1);
      step();
      chk("mis_exc_pulse", exc_valid, 0);
      chk("mis_no_req2", req_valid, 0);
      return;
    end
    chk("issue_req_valid", req_valid, 1);
    chk("issue_addr", req_addr, v.addr);
    chk("issue_we", write_en, v.is_store);
    chk("issue_size", d_size, v.size);
    chk("issue_sign", d_sign, v.sign);
    chk("issue_ex_ready", ex_ready, 0);
    if (v.is_store) chk("issue_wdata", write_data, v.wdata);
    step();
    resp_ready = 1'b0;
    #1 chk("req_one_cycle", req_valid, 0);
    step();
    for (int i = 0; i < v.busy; i++) begin
      chk("busy_req_valid", req_valid, 0);
      chk("busy_addr", req_addr, v.addr);
      chk("busy_we", write_en, v.is_store);
      chk("busy_ex_ready", ex_ready, 0);
      if (v.is_store) chk("busy_wdata", write_data, v.wdata);
      step();
    end
    if (!v.is_store) begin
      resp_valid = 1'b1;
      resp_data  = v.rdata;
      #1 chk("pre_wb_valid", wb_valid, 0);
      chk("pre_wb_addr", req_addr, v.addr);
      step();
      resp_valid = 1'b0; resp_ready = 1'b1; resp_data = '0;
      #1;
      chk("wb_valid", wb_valid, 1);
      chk("wb_data", wb_data, v.rdata);
      chk("wb_rd", wb_rd, v.rd);
      chk("wb_ex_ready", ex_ready, 1);
      step();
      chk("wb_pulse", wb_valid, 0);
    end else begin
      chk("st_ex_ready_busy", ex_ready, 0);
      resp_ready = 1'b1;
      step();
      chk("st_ex_ready_done", ex_ready, 1);
      chk("st_no_wb", wb_valid, 0);
      step();
      chk("st_no_wb2", wb_valid, 0);
    end
  endtask

  initial begin
    //        st    addr     sz  sg  rd  wdata         rdata         busy exc cause
    vecs[0] = '{1'b0, 32'h100, 2'd2, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF, 0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 32'h204, 2'd2, 1'b0, 5'd0,  32'h12345678, 32'h0,        6, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 32'h101, 2'd1, 1'b0, 5'd1,  32'h0,        32'h0,        0, 1'b1, 2'd0};
    vecs[3] = '{1'b1, 32'h202, 2'd2, 1'b0, 5'd0,  32'hCAFEF00D, 32'h0,        0, 1'b1, 2'd1};
    vecs[4] = '{1'b0, 32'h303, 2'd0, 1'b1, 5'd7,  32'h0,        32'hFFFFFF80, 2, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 32'h102, 2'd1, 1'b0, 5'd9,  32'h0,        32'h0000BEEF, 1, 1'b0, 2'd0};
    vecs[6] = '{1'b1, 32'h206, 2'd1, 1'b0, 5'd0,  32'h0000ABCD, 32'h0,        0, 1'b0, 2'd0};
    vecs[7] = '{1'b0, 32'h103, 2'd2, 1'b0, 5'd2,  32'h0,        32'h0,        0, 1'b1, 2'd0};
    vecs[8] = '{1'b1, 32'h003, 2'd0, 1'b0, 5'd0,  32'h000000A5, 32'h0,        0, 1'b0, 2'd0};

    #12;
    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_we", write_en, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Flush during the refill of an issued LB: dcache completes, no wb pulse.
    drive_op(1'b0, 32'h300, 2'd0, 1'b0, 5'd3, 32'h0);
    step();
    ex_valid = 1'b0;
    #1 chk("fl_issue_req", req_valid, 1);
    step();
    resp_ready = 1'b0;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fl_ex_ready_busy", ex_ready, 0);
      chk("fl_wb_busy", wb_valid, 0);
      step();
    end
    resp_valid = 1'b1; resp_data = 32'h00000055;
    step();
    resp_valid = 1'b0; resp_ready = 1'b1; resp_data = '0;
    #1 chk("fl_no_wb", wb_valid, 0);
    chk("fl_ex_ready", ex_ready, 1);
    step();
    chk("fl_no_wb2", wb_valid, 0);
    run_vec(vecs[0]);

    // Flush in ISSUE before the dcache is ready: op dropped.
    resp_ready = 1'b0;
    drive_op(1'b0, 32'h400, 2'd2, 1'b0, 5'd4, 32'h0);
    step();
    ex_valid = 1'b0;
    #1 chk("fi_no_req", req_valid, 0);
    chk("fi_ex_ready", ex_ready, 0);
    step();
    flush = 1'b1;
    #1 chk("fi_no_req_flush", req_valid, 0);
    step();
    flush = 1'b0; resp_ready = 1'b1;
    #1 chk("fi_idle", ex_ready, 1);
    chk("fi_no_req_after", req_valid, 0);
    chk("fi_no_exc", exc_valid, 0);
    chk("fi_no_wb", wb_valid, 0);

    // Flush with accept in the same cycle: accept ignored (legal and misaligned).
    drive_op(1'b0, 32'h500, 2'd2, 1'b0, 5'd4, 32'h0);
    flush = 1'b1;
    step();
    #1 chk("fa_no_issue", req_valid, 0);
    chk("fa_ex_ready", ex_ready, 1);
    drive_op(1'b0, 32'h501, 2'd1, 1'b0, 5'd4, 32'h0);
    step();
    ex_valid = 1'b0; flush = 1'b0;
    #1 chk("fa_no_mis_exc", exc_valid, 0);
    step();

    // Timeout: dcache never comes back within TO wait cycles.
    drive_op(1'b0, 32'h600, 2'd2, 1'b0, 5'd4, 32'h0);
    step();
    ex_valid = 1'b0;
    #1 chk("to_req", req_valid, 1);
    step();
    resp_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      chk("to_no_exc_yet", exc_valid, 0);
      chk("to_busy", ex_ready, 0);
    end
    step();
    chk("to_exc_valid", exc_valid, 1);
    chk("to_exc_cause", exc_cause, 2);
    chk("to_exc_addr", exc_addr, 32'h600);
    chk("to_ex_ready", ex_ready, 1);
    resp_valid = 1'b1; resp_data = 32'h77777777;
    step();
    resp_valid = 1'b0; resp_ready = 1'b1; resp_data = '0;
    #1 chk("to_late_no_wb", wb_valid, 0);
    chk("to_exc_pulse", exc_valid, 0);
    step();
    chk("to_late_no_wb2", wb_valid, 0);
    run_vec(vecs[5]);

    // Asynchronous reset while waiting on the dcache.
    drive_op(1'b0, 32'h100, 2'd2, 1'b0, 5'd6, 32'h0);
    step();
    ex_valid = 1'b0;
    step();
    resp_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ex_ready", ex_ready, 1);
    chk("arst_req_valid", req_valid, 0);
    chk("arst_req_addr", req_addr, 0);
    chk("arst_we", write_en, 0);
    chk("arst_wdata", write_data, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_exc_valid", exc_valid, 0);
    resp_ready = 1'b1; resp_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    run_vec(vecs[1]);
    run_vec(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
